// File: rtl/mem_sram_bridge.sv
// mem_sram_bridge: converts cache req/gnt/rvalid transactions into single-port SRAM accesses,
// one at a time, with configurable wait states and error responses outside the SRAM window.
module mem_sram_bridge #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_req_i,
    input  logic [31:0]           mem_addr_i,
    input  logic                  mem_we_i,
    input  logic [3:0]            mem_be_i,
    input  logic [31:0]           mem_wdata_i,
    output logic                  mem_gnt_o,
    output logic                  mem_rvalid_o,
    output logic [31:0]           mem_rdata_o,
    output logic                  mem_error_o,
    output logic                  sram_en_o,
    output logic                  sram_we_o,
    output logic [3:0]            sram_be_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i,
    output logic                  busy_o
);
    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_LATCH, S_WAIT, S_RESP} state_t;
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << ADDR_WIDTH);
    state_t                state;
    logic [ADDR_WIDTH-1:0] word_q;
    logic [31:0]           wdata_q, rdata_q;
    logic [3:0]            be_q, cnt;
    logic                  we_q, in_range_q, access, resp;
    assign access       = state == S_ACCESS && in_range_q;
    assign resp         = state == S_RESP;
    assign mem_gnt_o    = reset_n && mem_req_i && (state == S_IDLE || resp);
    assign mem_rvalid_o = resp;
    assign mem_rdata_o  = resp ? rdata_q : '0;
    assign mem_error_o  = resp && !in_range_q;
    assign sram_en_o    = access;
    assign sram_we_o    = access && we_q;
    assign sram_be_o    = (access && we_q) ? be_q : '0;
    assign sram_addr_o  = access ? word_q : '0;
    assign sram_wdata_o = access ? wdata_q : '0;
    assign busy_o       = state != S_IDLE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            word_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            be_q       <= '0;
            cnt        <= '0;
            we_q       <= 1'b0;
            in_range_q <= 1'b0;
        end else begin
            if (mem_gnt_o) begin
                // BASE_ADDR is word aligned, so the word index is a borrow-free slice difference
                word_q     <= mem_addr_i[ADDR_WIDTH+1:2] - BASE_ADDR[ADDR_WIDTH+1:2];
                wdata_q    <= mem_wdata_i;
                be_q       <= mem_be_i;
                we_q       <= mem_we_i;
                in_range_q <= {1'b0, mem_addr_i} >= {1'b0, BASE_ADDR} && {1'b0, mem_addr_i} < LIMIT;
            end
            case (state)
                S_IDLE, S_RESP: state <= mem_gnt_o ? S_ACCESS : S_IDLE;
                S_ACCESS: state <= S_LATCH;
                S_LATCH: begin
                    rdata_q <= (in_range_q && !we_q) ? sram_rdata_i : '0;
                    cnt     <= 4'(WAIT_CYCLES - 1);
                    state   <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd0) state <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_sram_bridge.sv
// tb_mem_sram_bridge: two bridges (0 and 3 wait states) on bench SRAMs, checked every cycle
// against a transaction-level timing/memory model plus hand-computed directed expectations.
module tb_mem_sram_bridge;
    localparam logic [31:0] BASE = 32'h0010_0000;
    logic        clk, reset_n;
    logic        req[2], we[2], gnt[2], rv[2], err[2], sen[2], swe[2], busy[2];
    logic [31:0] addr[2], wdata[2], rdata_o[2], srd[2], swd[2];
    logic [3:0]  be[2], sbe[2];
    logic [9:0]  sad[2];
    logic [31:0] sram[2][1024];
    logic [31:0] mmem[2][1024];
    int          last_g[2];
    logic [31:0] m_addr[2], m_wd[2];
    logic        m_we[2], m_inr[2];
    logic [3:0]  m_be[2];
    int          cyc = 0, pass_cnt = 0, chk_cnt = 0;
    logic [3:0]  last_sb;
    int          last_gw;

    for (genvar k = 0; k < 2; k++) begin : u
        mem_sram_bridge #(.WAIT_CYCLES(k * 3)) dut (
            .clk(clk), .reset_n(reset_n), .mem_req_i(req[k]), .mem_addr_i(addr[k]),
            .mem_we_i(we[k]), .mem_be_i(be[k]), .mem_wdata_i(wdata[k]), .mem_gnt_o(gnt[k]),
            .mem_rvalid_o(rv[k]), .mem_rdata_o(rdata_o[k]), .mem_error_o(err[k]),
            .sram_en_o(sen[k]), .sram_we_o(swe[k]), .sram_be_o(sbe[k]), .sram_addr_o(sad[k]),
            .sram_wdata_o(swd[k]), .sram_rdata_i(srd[k]), .busy_o(busy[k]));
    end

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        for (int i = 0; i < 2; i++)
            if (sen[i]) begin
                if (swe[i]) begin
                    for (int b = 0; b < 4; b++)
                        if (sbe[i][b]) sram[i][sad[i]][8*b+:8] <= swd[i][8*b+:8];
                end else begin
                    srd[i] <= sram[i][sad[i]];
                end
            end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic in_win(input logic [31:0] a);
        logic [63:0] x;
        x = {32'b0, a};
        return x >= 64'(BASE) && x < 64'(BASE) + 64'd4096;
    endfunction

    function automatic logic [9:0] widx(input logic [31:0] a);
        return 10'((a - BASE) >> 2);
    endfunction

    // Transaction-level model: a grant at cycle g means SRAM access at g+1, response at g+3+W.
    always @(negedge clk)
        for (int i = 0; i < 2; i++) begin
            automatic int w = i * 3;
            automatic int d = cyc - last_g[i];
            automatic logic e_busy, e_en, e_rv, e_gnt;
            automatic logic [9:0] e_idx;
            automatic logic [31:0] e_rd;
            if (!reset_n) begin
                chk($sformatf("rst_gnt%0d", i), 32'(gnt[i]), 0);
                chk($sformatf("rst_rvalid%0d", i), 32'(rv[i]), 0);
                chk($sformatf("rst_rdata%0d", i), rdata_o[i], 0);
                chk($sformatf("rst_err%0d", i), 32'(err[i]), 0);
                chk($sformatf("rst_en%0d", i), 32'(sen[i]), 0);
                chk($sformatf("rst_we%0d", i), 32'(swe[i]), 0);
                chk($sformatf("rst_be%0d", i), 32'(sbe[i]), 0);
                chk($sformatf("rst_addr%0d", i), 32'(sad[i]), 0);
                chk($sformatf("rst_wdata%0d", i), swd[i], 0);
                chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
                last_g[i] = -1000;
            end else begin
                e_busy = d >= 1 && d <= 3 + w;
                e_en   = d == 1 && m_inr[i];
                e_rv   = d == 3 + w;
                e_gnt  = req[i] && !(d >= 1 && d < 3 + w);
                e_idx  = widx(m_addr[i]);
                e_rd   = (e_rv && m_inr[i] && !m_we[i]) ? mmem[i][e_idx] : 32'h0;
                chk($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(e_gnt));
                chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(e_busy));
                chk($sformatf("rvalid%0d", i), 32'(rv[i]), 32'(e_rv));
                chk($sformatf("rdata%0d", i), rdata_o[i], e_rd);
                chk($sformatf("err%0d", i), 32'(err[i]), 32'(e_rv && !m_inr[i]));
                chk($sformatf("sram_en%0d", i), 32'(sen[i]), 32'(e_en));
                chk($sformatf("sram_we%0d", i), 32'(swe[i]), 32'(e_en && m_we[i]));
                chk($sformatf("sram_be%0d", i), 32'(sbe[i]), (e_en && m_we[i]) ? 32'(m_be[i]) : 0);
                chk($sformatf("sram_addr%0d", i), 32'(sad[i]), e_en ? 32'(e_idx) : 0);
                chk($sformatf("sram_wdata%0d", i), swd[i], e_en ? m_wd[i] : 0);
                if (e_en && m_we[i])
                    for (int b = 0; b < 4; b++)
                        if (m_be[i][b]) mmem[i][e_idx][8*b+:8] = m_wd[i][8*b+:8];
                if (e_gnt) begin
                    last_g[i] = cyc;
                    m_addr[i] = addr[i];
                    m_we[i]   = we[i];
                    m_be[i]   = be[i];
                    m_wd[i]   = wdata[i];
                    m_inr[i]  = in_win(addr[i]);
                end
            end
        end

    task automatic xact(input int i, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat, output int gw, output logic [9:0] sa, output logic se,
                        output logic [3:0] sb);
        @(posedge clk); #1;
        req[i] = 1; addr[i] = a; we[i] = w; be[i] = b; wdata[i] = d;
        gw = 0;
        do begin @(negedge clk); gw++; end while (!gnt[i] && gw < 40);
        @(posedge clk); #1;
        req[i] = 0;
        @(negedge clk);
        sa = sad[i]; se = sen[i]; sb = sbe[i]; lat = 1;
        do begin @(negedge clk); lat++; end while (!rv[i] && lat < 40);
        rd = rdata_o[i]; er = err[i];
    endtask

    task automatic run(input string nm, input int i, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d, input logic [31:0] erd,
                       input logic eer, input logic [9:0] esa, input logic ese);
        logic [31:0] rd;
        logic er, se;
        logic [9:0] sa;
        int lat;
        xact(i, a, w, b, d, rd, er, lat, last_gw, sa, se, last_sb);
        chk({nm, "_latency"}, 32'(lat), 32'(3 + 3 * i));
        chk({nm, "_rdata"}, rd, erd);
        chk({nm, "_error"}, 32'(er), 32'(eer));
        chk({nm, "_sram_addr"}, 32'(sa), 32'(esa));
        chk({nm, "_sram_en"}, 32'(se), 32'(ese));
    endtask

    initial begin
        int gc[4];
        int k;
        reset_n = 0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; we[i] = 0; be[i] = 0; addr[i] = 0; wdata[i] = 0;
            last_g[i] = -1000; m_addr[i] = 0; m_we[i] = 0; m_be[i] = 0; m_wd[i] = 0; m_inr[i] = 0;
            for (int j = 0; j < 1024; j++) begin sram[i][j] = 0; mmem[i][j] = 0; end
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1;
        run("wr8", 0, BASE + 8, 1, 4'hF, 32'hDEADBEEF, 0, 0, 2, 1);
        run("rd8", 0, BASE + 8, 0, 4'h0, 0, 32'hDEADBEEF, 0, 2, 1);
        run("wr20", 0, BASE + 20, 1, 4'hF, 32'hAABBCCDD, 0, 0, 5, 1);
        run("wrmask", 0, BASE + 20, 1, 4'b0101, 32'h11223344, 0, 0, 5, 1);
        chk("mask_sram_be", 32'(last_sb), 32'h5);
        run("rdmask", 0, BASE + 20, 0, 4'h0, 0, 32'hAA22CC44, 0, 5, 1);
        run("oor_lo", 0, BASE - 4, 0, 4'h0, 0, 0, 1, 0, 0);
        run("oor_hi", 0, 32'hFFFF_FFFC, 0, 4'h0, 0, 0, 1, 0, 0);
        run("oor_end", 0, BASE + 4096, 1, 4'hF, 32'h12345678, 0, 1, 0, 0);
        run("wr_last", 0, BASE + 4095, 1, 4'hF, 32'hCAFEF00D, 0, 0, 1023, 1);
        run("rd_last", 0, BASE + 4092, 0, 4'h0, 0, 32'hCAFEF00D, 0, 1023, 1);
        run("w3_wr", 1, BASE + 12, 1, 4'hF, 32'h0BADCAFE, 0, 0, 3, 1);
        run("w3_rd", 1, BASE + 12, 0, 4'h0, 0, 32'h0BADCAFE, 0, 3, 1);
        @(posedge clk); #1;
        req[1] = 1; addr[1] = BASE + 12; we[1] = 0; be[1] = 0;
        k = 0;
        for (int n = 0; n < 60 && k < 4; n++) begin
            @(negedge clk);
            if (gnt[1]) begin
                gc[k] = cyc;
                if (k > 0) chk("b2b_rvalid_at_gnt", 32'(rv[1]), 1);
                k++;
            end
        end
        @(posedge clk); #1 req[1] = 0;
        chk("b2b_grant_count", 32'(k), 4);
        for (int j = 1; j < k; j++) chk("b2b_spacing", 32'(gc[j] - gc[j-1]), 6);
        repeat (10) @(posedge clk);
        #1;
        req[0] = 1; addr[0] = BASE + 8; we[0] = 1; be[0] = 4'hF; wdata[0] = 32'h12345678;
        @(negedge clk);
        chk("rstw_gnt", 32'(gnt[0]), 1);
        @(posedge clk); #1;
        req[0] = 0;
        chk("rstw_en_access", 32'(sen[0]), 1);
        #1 reset_n = 0;
        #1;
        chk("rstw_async_en", 32'(sen[0]), 0);
        chk("rstw_async_we", 32'(swe[0]), 0);
        chk("rstw_async_busy", 32'(busy[0]), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        run("rd8_after_rst", 0, BASE + 8, 0, 4'h0, 0, 32'hDEADBEEF, 0, 2, 1);
        chk("rst_gnt_immediate", 32'(last_gw), 1);
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
